sram_packet_loader: RTL and testbench
=====================================

Name: sram_packet_loader

Overview:
Serial-to-parallel front end for the SRAM test-chip datapath. Assembles a 56-bit serial frame into a chip_select bit and a 55-bit packet, and presents them to the SRAM_IN control logic. It holds the packet stable for a fixed issue window, then returns the interface to an idle packet so the macros see no spurious access. Sits between the chip-level serial pins and SRAM_IN.

Parameters:
PACKET_WIDTH, 55, width of the packet bus consumed by SRAM_IN
HOLD_CYCLES, 2, clk_in cycles the issued packet is presented with packet_valid high (min 1)
IDLE_PACKET, {55{1'b1}}, packet value driven whenever no packet is being issued (both ports deselected, web=1)
READ_LAT, 2, cycles from end of issue to read_data capture (used only with the optional feature)

Ports:
clk_in  input  1  single clock; all logic on its rising edge
reset_in  input  1  synchronous, active-high reset
sin  input  1  serial data, sampled when shift_en=1
shift_en  input  1  qualifies one frame bit per cycle
chip_select  output  1  SRAM select forwarded to SRAM_IN/SRAM_OUT (first frame bit)
packet  output  PACKET_WIDTH  packet to SRAM_IN
packet_valid  output  1  high exactly while the issued packet is on packet
busy  output  1  high in ISSUE (and WAIT when the feature is enabled)
overrun  output  1  sticky; set when shift_en=1 while busy
read_data  input  32  SRAM_OUT result (feature only)
sout  output  1  serial readback bit (feature only)

Behaviour:
- Reset (reset_in=1 at clk edge): state=IDLE, bit_cnt=0, shift_reg=0, packet=IDLE_PACKET, chip_select=0, packet_valid=0, busy=0, overrun=0, sout=0. Reset mid-shift or mid-issue discards the frame immediately, with no partial issue.
- Frame: FRAME_W=PACKET_WIDTH+1 bits. The first accepted bit is chip_select, followed by the packet MSB-first (bit 54 first, bit 0 last).
- States:
  IDLE: shift_en=1 -> shift sin into shift_reg, bit_cnt=1, go to SHIFT.
  SHIFT: each shift_en=1 cycle shifts one bit and increments bit_cnt. shift_en=0 holds, with no timeout. On the cycle the FRAME_W-th bit is accepted, go to ISSUE on the next edge and clear bit_cnt.
  ISSUE: packet/chip_select come from shift_reg. packet_valid=1 and busy=1 for exactly HOLD_CYCLES cycles, then go to IDLE (or WAIT with the feature).
- Latency: last bit sampled at edge N -> packet_valid=1 from after edge N+1 through edge N+1+HOLD_CYCLES.
- Outside ISSUE: packet=IDLE_PACKET and packet_valid=0. chip_select keeps its last issued value so SRAM_OUT muxing stays stable.
- shift_en while busy: the bit is ignored, overrun is set, and the issued packet is unaffected. overrun clears only on reset.
- Back-to-back frames: shifting may restart on the first IDLE cycle after ISSUE. No bit is lost if shift_en rises on that cycle.
- bit_cnt is 6 bits wide and never wraps past FRAME_W-1.

Optional Feature:
Macro SRAM_PACKET_READBACK_EN.
- With it: after ISSUE the block enters WAIT for READ_LAT cycles (busy=1), then captures read_data into rdata_reg and goes to IDLE. While the next frame is shifted in, each accepted bit also shifts rdata_reg out MSB-first on sout. sout is registered and shows bit 31 after capture.
- Without it: the read_data and sout ports are absent, there is no WAIT state, and ISSUE returns directly to IDLE.

Decomposition:
- Shared package: state encoding (IDLE, SHIFT, ISSUE, WAIT), FRAME_W, and packet field offsets. The offsets are SEL bit 54, WEB 53, WMASK 52:49, ADDR 48:41, WDATA 40:9, CSB_RO 8, ADDR_RO 7:0, and are shared with SRAM_IN.
- One natural sub-module, sram_frame_shifter: shift register plus bit counter with a frame_done pulse. The FSM and output registers stay in the top.

Test Plan:
- Reset then idle 10 cycles -> packet=all ones, packet_valid=0, chip_select=0, overrun=0.
- Shift frame cs=0 + {1,1,4'd0,8'd0,32'd1,1'b0,8'd0} contiguously -> packet_valid high 2 cycles starting 1 cycle after last bit, packet matches exactly, then packet returns to IDLE_PACKET.
- Same frame with shift_en gapped randomly (1-5 idle cycles between bits) -> identical packet; issue timing referenced to the last bit.
- shift_en=1 during ISSUE -> overrun=1 and stays 1; issued packet unchanged; reset clears it.
- Assert reset_in at bit 30 of a frame, then send a full new frame -> only the new frame is issued, with no packet_valid from the aborted one.
- With SRAM_PACKET_READBACK_EN: write 32'hA5A5_0F0F to addr 8'h10, then issue a read of addr 8'h10 -> during the next frame, sout emits A5A50F0F MSB-first on the first 32 accepted bits.

Source files
------------

// File: rtl/sram_packet_loader_pkg.sv
// Shared definitions for the serial SRAM packet loader: FSM encoding, frame width
// and packet field offsets (the offsets are also used by SRAM_IN).
package sram_packet_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam int PACKET_W = 55;
    localparam int FRAME_W  = PACKET_W + 1;

    // Packet field positions, MSB..LSB
    localparam int SEL_BIT       = 54;
    localparam int WEB_BIT       = 53;
    localparam int WMASK_MSB     = 52;
    localparam int WMASK_LSB     = 49;
    localparam int ADDR_MSB      = 48;
    localparam int ADDR_LSB      = 41;
    localparam int WDATA_MSB     = 40;
    localparam int WDATA_LSB     = 9;
    localparam int CSB_RO_BIT    = 8;
    localparam int ADDR_RO_MSB   = 7;
    localparam int ADDR_RO_LSB   = 0;

endpackage

// File: rtl/sram_packet_loader_if.sv
// Serial-in / packet-out bus of the SRAM packet loader.
// Readback signals exist only when SRAM_PACKET_READBACK_EN is defined.
interface sram_packet_loader_if #(
    parameter int PACKET_WIDTH = 55
);
    logic                    sin;
    logic                    shift_en;
    logic                    chip_select;
    logic [PACKET_WIDTH-1:0] packet;
    logic                    packet_valid;
    logic                    busy;
    logic                    overrun;
`ifdef SRAM_PACKET_READBACK_EN
    logic [31:0]             read_data;
    logic                    sout;
`endif

    modport slave (
        input  sin, shift_en,
        output chip_select, packet, packet_valid, busy, overrun
`ifdef SRAM_PACKET_READBACK_EN
        , input read_data
        , output sout
`endif
    );

    modport master (
        output sin, shift_en,
        input  chip_select, packet, packet_valid, busy, overrun
`ifdef SRAM_PACKET_READBACK_EN
        , output read_data
        , input  sout
`endif
    );

endinterface

// File: rtl/sram_packet_loader_frame_shifter.sv
// sram_frame_shifter: MSB-first frame shift register with a bit counter and a
// registered frame_done pulse the cycle after the last frame bit is accepted.
module sram_frame_shifter
    import sram_packet_loader_pkg::*;
#(
    parameter int FRAME_W_P = FRAME_W
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic                 shift,
    input  logic                 sin,
    output logic [FRAME_W_P-1:0] shift_reg,
    output logic                 frame_done
);

    localparam logic [5:0] LAST_BIT = 6'(FRAME_W_P - 1);

    logic [5:0] bit_cnt;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (shift) begin
                shift_reg <= {shift_reg[FRAME_W_P-2:0], sin};
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 6'd1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_packet_loader.sv
// Serial-to-parallel SRAM packet loader: assembles chip_select + packet, issues it
// for HOLD_CYCLES, then restores IDLE_PACKET. Optional feature: SRAM_PACKET_READBACK_EN.
module sram_packet_loader
    import sram_packet_loader_pkg::*;
#(
    parameter int                      PACKET_WIDTH = 55,
    parameter int                      HOLD_CYCLES  = 2,
    parameter logic [PACKET_WIDTH-1:0] IDLE_PACKET  = '1,
    parameter int                      READ_LAT     = 2
) (
    input logic                 clk_in,
    input logic                 reset_in,
    sram_packet_loader_if.slave bus
);

    localparam int         FRAME_W_L = PACKET_WIDTH + 1;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES);

    state_t                 state;
    logic [7:0]             cnt;
    logic [FRAME_W_L-1:0]   shift_reg;
    logic                   frame_done;
    logic                   accept;

    // Bits arriving in the gap between the last frame bit and ISSUE are dropped.
    assign accept = bus.shift_en && !frame_done &&
                    ((state == ST_IDLE) || (state == ST_SHIFT));

    sram_frame_shifter #(.FRAME_W_P(FRAME_W_L)) u_shifter (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .shift      (accept),
        .sin        (bus.sin),
        .shift_reg  (shift_reg),
        .frame_done (frame_done)
    );

`ifdef SRAM_PACKET_READBACK_EN
    localparam logic [7:0] READ_LAST = 8'(READ_LAT);
    logic [31:0] rdata_reg;
`endif

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            bus.packet       <= IDLE_PACKET;
            bus.chip_select  <= 1'b0;
            bus.packet_valid <= 1'b0;
            bus.busy         <= 1'b0;
            bus.overrun      <= 1'b0;
`ifdef SRAM_PACKET_READBACK_EN
            rdata_reg        <= '0;
            bus.sout         <= 1'b0;
`endif
        end else begin
            if (bus.shift_en && bus.busy)
                bus.overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (accept)
                        state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (frame_done) begin
                        state            <= ST_ISSUE;
                        bus.packet       <= shift_reg[PACKET_WIDTH-1:0];
                        bus.chip_select  <= shift_reg[PACKET_WIDTH];
                        bus.packet_valid <= 1'b1;
                        bus.busy         <= 1'b1;
                        cnt              <= 8'd1;
                    end
                end
                ST_ISSUE: begin
                    if (cnt == HOLD_LAST) begin
                        bus.packet_valid <= 1'b0;
                        bus.packet       <= IDLE_PACKET;
`ifdef SRAM_PACKET_READBACK_EN
                        state            <= ST_WAIT;
                        cnt              <= 8'd1;
`else
                        state            <= ST_IDLE;
                        bus.busy         <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
`ifdef SRAM_PACKET_READBACK_EN
                ST_WAIT: begin
                    if (cnt == READ_LAST) begin
                        state     <= ST_IDLE;
                        bus.busy  <= 1'b0;
                        rdata_reg <= bus.read_data;
                        bus.sout  <= bus.read_data[31];
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase

`ifdef SRAM_PACKET_READBACK_EN
            // Each accepted bit of the next frame advances the readback word.
            if (accept) begin
                rdata_reg <= {rdata_reg[30:0], 1'b0};
                bus.sout  <= rdata_reg[30];
            end
`endif
        end
    end

endmodule

// File: tb/tb_sram_packet_loader.sv
// Directed self-checking bench for sram_packet_loader (default build).
module tb_sram_packet_loader;

    localparam logic [54:0] ONES = {55{1'b1}};
    // cs=0, SEL=1, WEB=1, WMASK=0, ADDR=0, WDATA=1, CSB_RO=0, ADDR_RO=0
    localparam logic [54:0] P1 = 55'h60_0000_0000_0200;
    localparam logic [55:0] F1 = {1'b0, P1};
    localparam logic [54:0] P2 = 55'h12_3456_789A_BCDE;
    localparam logic [55:0] F2 = {1'b1, P2};

    logic clk_in = 1'b0;
    logic reset_in;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_in = ~clk_in;

    sram_packet_loader_if #(.PACKET_WIDTH(55)) bus ();

    sram_packet_loader dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.sin      = b;
        bus.shift_en = 1'b1;
        tick();
        bus.shift_en = 1'b0;
    endtask

    // Returns #1 after the edge that accepted the last bit.
    task automatic send_frame(input logic [55:0] f, input bit gapped);
        for (int i = 55; i >= 0; i--) begin
            send_bit(f[i]);
            if (gapped && i != 0)
                repeat ($urandom_range(1, 5)) tick();
        end
    endtask

    task automatic check_issue(input string tag, input logic cs, input logic [54:0] p);
        chk({tag, "_pre_valid"}, 64'(bus.packet_valid), 64'd0);
        tick();
        chk({tag, "_valid1"}, 64'(bus.packet_valid), 64'd1);
        chk({tag, "_busy1"}, 64'(bus.busy), 64'd1);
        chk({tag, "_packet1"}, 64'(bus.packet), 64'(p));
        chk({tag, "_cs"}, 64'(bus.chip_select), 64'(cs));
        tick();
        chk({tag, "_valid2"}, 64'(bus.packet_valid), 64'd1);
        chk({tag, "_packet2"}, 64'(bus.packet), 64'(p));
        tick();
        chk({tag, "_valid_end"}, 64'(bus.packet_valid), 64'd0);
        chk({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
        chk({tag, "_packet_idle"}, 64'(bus.packet), 64'(ONES));
        chk({tag, "_cs_hold"}, 64'(bus.chip_select), 64'(cs));
    endtask

    initial begin
        bit seen_valid;
        reset_in     = 1'b1;
        bus.sin      = 1'b0;
        bus.shift_en = 1'b0;
        repeat (2) tick();
        reset_in = 1'b0;
        repeat (10) tick();
        chk("rst_packet", 64'(bus.packet), 64'(ONES));
        chk("rst_valid", 64'(bus.packet_valid), 64'd0);
        chk("rst_cs", 64'(bus.chip_select), 64'd0);
        chk("rst_overrun", 64'(bus.overrun), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);

        send_frame(F1, 1'b0);
        check_issue("contig", 1'b0, P1);

        send_frame(F1, 1'b1);
        check_issue("gapped", 1'b0, P1);

        // Next frame starts on the first IDLE cycle after ISSUE
        send_frame(F2, 1'b0);
        check_issue("b2b", 1'b1, P2);
        repeat (3) tick();
        chk("cs_sticky", 64'(bus.chip_select), 64'd1);

        send_frame(F1, 1'b0);
        tick();
        chk("ovr_valid", 64'(bus.packet_valid), 64'd1);
        chk("ovr_pre", 64'(bus.overrun), 64'd0);
        bus.sin      = 1'b1;
        bus.shift_en = 1'b1;
        tick();
        bus.shift_en = 1'b0;
        chk("ovr_set", 64'(bus.overrun), 64'd1);
        chk("ovr_packet", 64'(bus.packet), 64'(P1));
        chk("ovr_valid2", 64'(bus.packet_valid), 64'd1);
        tick();
        chk("ovr_valid_end", 64'(bus.packet_valid), 64'd0);
        repeat (5) tick();
        chk("ovr_sticky", 64'(bus.overrun), 64'd1);
        chk("ovr_no_issue", 64'(bus.packet_valid), 64'd0);
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        chk("ovr_cleared", 64'(bus.overrun), 64'd0);
        chk("ovr_rst_packet", 64'(bus.packet), 64'(ONES));

        // Abort a frame at bit 30 with reset, then send a clean frame
        for (int i = 55; i >= 26; i--) send_bit(F2[i]);
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        chk("abort_cs", 64'(bus.chip_select), 64'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.packet_valid) seen_valid = 1'b1;
        end
        chk("abort_no_valid", 64'(seen_valid), 64'd0);
        send_frame(F2, 1'b0);
        check_issue("after_abort", 1'b1, P2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
